// File: rtl/xint_ctrl.sv
// rtl/xint_ctrl.sv - external interrupt controller: synchronizers, pending/mask/mode registers,
// fixed or rotating priority, IDLE/REQ/SERV request handshake with Wishbone register access.
module xint_ctrl #(
    parameter int NSRC        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            xint_clr,
    input  logic [NSRC-1:0] xint_src,
    output logic            irq_o,
    output logic [1:0]      irq_vec,
    input  logic            irq_ack,
    input  logic [1:0]      WB_ADRi,
    input  logic [7:0]      WB_DATi,
    output logic [7:0]      WB_DATo,
    input  logic            WB_WEi,
    input  logic            WB_CYCi,
    input  logic            WB_STBi,
    output logic            WB_ACKo
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERV} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NSRC-1:0] r_sync [SYNC_STAGES];
    logic [NSRC-1:0] r_sync_d;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_en;
    logic [NSRC-1:0] r_edge_mode;
    logic            r_rot_en;
    logic [1:0]      r_last_eoi;
    logic            r_irq;
    logic [1:0]      r_vec;
    logic            r_ack;

    logic [NSRC-1:0] w_sync_last;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pend_nxt;
    logic [3:0]      w_cand;
    logic [1:0]      w_start;
    logic [1:0]      w_idx;
    logic [1:0]      w_grant;
    logic            w_any;
    logic            w_busy;
    logic            w_wb_hit;
    logic            w_wr;
    logic            w_wr_pend;
    logic            w_eoi;
    logic            w_take_ack;
    logic            w_unused;

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_sync_last & ~r_sync_d;
    assign w_cand      = 4'(r_pend & r_en);
    assign w_any       = |w_cand;
    assign w_busy      = (r_state == ST_SERV);
    assign w_wb_hit    = WB_CYCi & WB_STBi & ~r_ack;
    assign w_wr        = w_wb_hit & WB_WEi;
    assign w_wr_pend   = w_wr & (WB_ADRi == 2'd0);
    assign w_eoi       = w_wr & (WB_ADRi == 2'd3) & w_busy;
    assign w_unused    = ^WB_DATi[7:5];

    assign irq_o   = r_irq;
    assign irq_vec = r_vec;
    assign WB_ACKo = r_ack;

    always_ff @(posedge clk or posedge xint_clr) begin
        if (xint_clr) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync[0] <= xint_src;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_sync_d <= w_sync_last;
        end
    end

    // Scan from lowest to highest priority so the highest-priority candidate is written last.
    always_comb begin
        w_start = r_rot_en ? (r_last_eoi + 2'd1) : 2'd0;
        w_grant = 2'd0;
        w_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = w_start + 2'(k);
            if (w_cand[w_idx]) w_grant = w_idx;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take_ack  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (irq_ack) begin
                    w_state_nxt = ST_SERV;
                    w_take_ack  = 1'b1;
                end else if (!w_cand[r_vec]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERV: if (w_eoi) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Edge sources: a new rising edge wins over a W1C or acknowledge clear in the same cycle.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < NSRC; i++) begin
            if (r_edge_mode[i]) begin
                w_pend_nxt[i] = (r_pend[i] & ~((w_wr_pend & WB_DATi[i]) |
                                (w_take_ack & (r_vec == 2'(i))))) | w_rise[i];
            end else begin
                w_pend_nxt[i] = w_sync_last[i];
            end
        end
    end

    always_ff @(posedge clk or posedge xint_clr) begin
        if (xint_clr) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge xint_clr) begin
        if (xint_clr) begin
            r_pend      <= '0;
            r_en        <= '0;
            r_edge_mode <= '0;
            r_rot_en    <= 1'b0;
            r_last_eoi  <= 2'd3;
            r_irq       <= 1'b0;
            r_vec       <= 2'd0;
            r_ack       <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ack  <= w_wb_hit;
            r_irq  <= (w_state_nxt == ST_REQ);
            if (r_state == ST_IDLE && w_any) r_vec <= w_grant;
            if (w_eoi) r_last_eoi <= r_vec;
            if (w_wr && WB_ADRi == 2'd1) r_en <= WB_DATi[NSRC-1:0];
            if (w_wr && WB_ADRi == 2'd2) begin
                r_edge_mode <= WB_DATi[NSRC-1:0];
                r_rot_en    <= WB_DATi[4];
            end
        end
    end

    always_comb begin
        WB_DATo = 8'h00;
        case (WB_ADRi)
            2'd0: WB_DATo = 8'(r_pend);
            2'd1: WB_DATo = 8'(r_en);
            2'd2: WB_DATo = 8'({r_rot_en, r_edge_mode});
            2'd3: WB_DATo = {w_busy, 5'b00000, r_vec};
            default: WB_DATo = 8'h00;
        endcase
    end

endmodule
